// File: rtl/decoder_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_scan_pkg
//  Description : Shared types and helpers for the decoder_scan block:
//                controller state encoding, mode encodings and the
//                one-hot output width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package decoder_scan_pkg;

    // Controller states. ST_BLANK is only reachable when the block is
    // built with DECODER_SCAN_BLANK_EN defined.
    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2,
        ST_BLANK  = 2'd3
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Number of one-hot outputs for a given select width (2**sel_w).
    function automatic int unsigned onehot_width(input int unsigned sel_w);
        return 32'd1 << sel_w;
    endfunction

endpackage : decoder_scan_pkg
`default_nettype wire

// File: rtl/decoder_scan_onehot_dec.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_dec
//  Description : Combinational SEL_W-to-2**SEL_W one-hot decoder with a
//                force-to-zero enable.
//  Ports       : en_i     - 0 forces the output to all-zero
//                code_i   - binary select code
//                onehot_o - one-hot decode of code_i (or zero)
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_dec
    import decoder_scan_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic                               en_i,
    input  logic [SEL_W-1:0]                   code_i,
    output logic [onehot_width(SEL_W)-1:0]     onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[code_i] = 1'b1;
        end
    end

endmodule : onehot_dec
`default_nettype wire

// File: rtl/decoder_scan.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_scan
//  Description : Registered binary-to-one-hot decoder with a latched select
//                code (DIRECT mode) and an autonomous scanning walk through
//                all positions with a programmable dwell (SCAN mode).
//  Ports       : sys_clk  - clock, rising edge
//                sys_rst  - synchronous active-high reset
//                en       - block enable, 0 forces outputs off
//                mode     - 0 = DIRECT, 1 = SCAN
//                sel_in   - select code, latched when sel_vld=1
//                sel_vld  - single-cycle strobe for sel_in
//                dwell    - cycles per scan position minus one
//                out      - registered one-hot (or zero) output
//                pos      - registered binary index of driven position
//                wrap     - one-cycle pulse when the scan returns to 0
//  Options     : DECODER_SCAN_BLANK_EN - insert a one-cycle all-zero BLANK
//                state between scan positions (anti-ghosting).
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_scan
    import decoder_scan_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 16
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst,
    input  logic                           en,
    input  logic                           mode,
    input  logic [SEL_W-1:0]               sel_in,
    input  logic                           sel_vld,
    input  logic [DWELL_W-1:0]             dwell,
    output logic [onehot_width(SEL_W)-1:0] out,
    output logic [SEL_W-1:0]               pos,
    output logic                           wrap
);

    localparam int               OUT_W   = onehot_width(SEL_W);
    localparam logic [SEL_W-1:0] POS_MAX = '1;

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     code_q, code_d;
    logic [SEL_W-1:0]     pos_q, pos_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]     out_q, out_d;
    logic                 wrap_q, wrap_d;
    logic                 drive_d;

    // Next-state logic. pos_d is always the index that will be driven next
    // cycle, so out and pos are loaded from the same decision on one edge.
    always_comb begin
        state_d = state_q;
        code_d  = sel_vld ? sel_in : code_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        drive_d = 1'b0;

        if (!en) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF, ST_DIRECT: begin
                    if (mode == MODE_SCAN) begin
                        state_d = ST_SCAN;
                        pos_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        // code_q equals pos_q while in DIRECT, so this both
                        // holds the output and applies a fresh strobe.
                        state_d = ST_DIRECT;
                        pos_d   = code_d;
                    end
                    drive_d = 1'b1;
                end
                ST_SCAN: begin
                    if (mode == MODE_DIRECT) begin
                        state_d = ST_DIRECT;
                        pos_d   = code_d;
                        drive_d = 1'b1;
                    end else if (cnt_q >= dwell) begin
                        // >= so a live dwell decrease never stalls the walk.
                        cnt_d = '0;
                        pos_d = pos_q + SEL_W'(1);
`ifdef DECODER_SCAN_BLANK_EN
                        state_d = ST_BLANK;
`else
                        drive_d = 1'b1;
                        wrap_d  = (pos_q == POS_MAX);
`endif
                    end else begin
                        cnt_d   = cnt_q + DWELL_W'(1);
                        drive_d = 1'b1;
                    end
                end
`ifdef DECODER_SCAN_BLANK_EN
                ST_BLANK: begin
                    if (mode == MODE_DIRECT) begin
                        state_d = ST_DIRECT;
                        pos_d   = code_d;
                    end else begin
                        // pos already advanced on entry to BLANK.
                        state_d = ST_SCAN;
                        cnt_d   = '0;
                        wrap_d  = (pos_q == '0);
                    end
                    drive_d = 1'b1;
                end
`endif
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    onehot_dec #(
        .SEL_W    (SEL_W)
    ) u_onehot_dec (
        .en_i     (drive_d),
        .code_i   (pos_d),
        .onehot_o (out_d)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_OFF;
            code_q  <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
        end
    end

    assign out  = out_q;
    assign pos  = pos_q;
    assign wrap = wrap_q;

endmodule : decoder_scan
`default_nettype wire

// File: tb/tb_decoder_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_scan
//  Description : Directed self-checking bench for decoder_scan. Uses an
//                8-output instance for DIRECT/SCAN/control tests and a
//                16-output instance for the dwell=0 scan.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_scan;

`ifdef DECODER_SCAN_BLANK_EN
    localparam int BLK = 1;
`else
    localparam int BLK = 0;
`endif

    logic        clk;
    logic        rst;
    logic        en, mode, sel_vld;
    logic [2:0]  sel_in;
    logic [15:0] dwell;
    logic [7:0]  out;
    logic [2:0]  pos;
    logic        wrap;

    logic        en4, mode4, sel_vld4;
    logic [3:0]  sel_in4;
    logic [7:0]  dwell4;
    logic [15:0] out4;
    logic [3:0]  pos4;
    logic        wrap4;

    int n_vec;
    int n_err;

    decoder_scan #(.SEL_W(3), .DWELL_W(16)) u_dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .en      (en),
        .mode    (mode),
        .sel_in  (sel_in),
        .sel_vld (sel_vld),
        .dwell   (dwell),
        .out     (out),
        .pos     (pos),
        .wrap    (wrap)
    );

    decoder_scan #(.SEL_W(4), .DWELL_W(8)) u_dut4 (
        .sys_clk (clk),
        .sys_rst (rst),
        .en      (en4),
        .mode    (mode4),
        .sel_in  (sel_in4),
        .sel_vld (sel_vld4),
        .dwell   (dwell4),
        .out     (out4),
        .pos     (pos4),
        .wrap    (wrap4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected scan behaviour k cycles after SCAN entry (k=0 is the first
    // cycle with out=1), for select width sw and dwell dw.
    function automatic int scan_pos(int k, int dw, int sw);
        int seg = dw + 1 + BLK;
        int n   = 1 << sw;
        if (BLK == 1 && (k % seg) == dw + 1) return ((k / seg) + 1) % n;
        return (k / seg) % n;
    endfunction

    function automatic logic [31:0] scan_out(int k, int dw, int sw);
        int seg = dw + 1 + BLK;
        if (BLK == 1 && (k % seg) == dw + 1) return 32'd0;
        return 32'd1 << scan_pos(k, dw, sw);
    endfunction

    function automatic logic [31:0] scan_wrap(int k, int dw, int sw);
        int seg = dw + 1 + BLK;
        return (k > 0 && (k % ((1 << sw) * seg)) == 0) ? 32'd1 : 32'd0;
    endfunction

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel_vld = 1'b0; sel_in = '0; dwell = '0;
        en4 = 1'b0; mode4 = 1'b0; sel_vld4 = 1'b0; sel_in4 = '0; dwell4 = '0;

        tick(); tick();
        check("rst_out", 32'(out), 32'h0);
        check("rst_pos", 32'(pos), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        rst = 1'b0;
        tick();
        check("off_out", 32'(out), 32'h0);

        // DIRECT: enable drives the latched code (0) after one edge.
        en = 1'b1; mode = 1'b0;
        tick();
        check("en_direct_out", 32'(out), 32'h01);
        sel_in = 3'd5; sel_vld = 1'b1;
        tick();
        sel_vld = 1'b0;
        check("dir5_out", 32'(out), 32'h20);
        check("dir5_pos", 32'(pos), 32'd5);
        for (int i = 0; i < 20; i++) begin
            sel_in = 3'(i);  // ignored without a strobe
            tick();
            check("dir5_hold_out", 32'(out), 32'h20);
            check("dir5_hold_wrap", 32'(wrap), 32'h0);
        end
        check("dir5_hold_pos", 32'(pos), 32'd5);
        // Back-to-back strobes.
        sel_in = 3'd2; sel_vld = 1'b1;
        tick();
        check("b2b_a_out", 32'(out), 32'h04);
        sel_in = 3'd7;
        tick();
        sel_vld = 1'b0;
        check("b2b_b_out", 32'(out), 32'h80);
        check("b2b_b_pos", 32'(pos), 32'd7);

        // SCAN with dwell=2 from DIRECT: restarts at position 0.
        dwell = 16'd2; mode = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            check("scan_out", 32'(out), scan_out(k, 2, 3));
            check("scan_pos", 32'(pos), 32'(scan_pos(k, 2, 3)));
            check("scan_wrap", 32'(wrap), scan_wrap(k, 2, 3));
        end

        // Disable then re-enable mid-scan at position 6.
        en = 1'b0;
        tick();
        en = 1'b1;
        for (int k = 0; k <= 6 * (3 + BLK); k++) tick();
        check("p6_pos", 32'(pos), 32'd6);
        check("p6_out", 32'(out), 32'h40);
        en = 1'b0;
        tick();
        check("dis_out", 32'(out), 32'h0);
        check("dis_wrap", 32'(wrap), 32'h0);
        check("dis_pos", 32'(pos), 32'd6);
        en = 1'b1;
        tick();
        check("reen_out", 32'(out), 32'h01);
        check("reen_pos", 32'(pos), 32'd0);

        // Strobe in SCAN only updates the latched code.
        sel_in = 3'd3; sel_vld = 1'b1;
        tick();
        sel_vld = 1'b0;
        check("scan_strobe_out", 32'(out), 32'h01);
        mode = 1'b0;
        tick();
        check("to_direct_out", 32'(out), 32'h08);
        check("to_direct_pos", 32'(pos), 32'd3);

        // Live dwell decrease below the current count advances next edge.
        mode = 1'b1; dwell = 16'd20;
        tick();
        for (int i = 0; i < 5; i++) tick();
        check("long_dwell_pos", 32'(pos), 32'd0);
        dwell = 16'd2;
        tick();
        check("dw_dec_pos", 32'(pos), 32'd1);
        check("dw_dec_out", 32'(out), (BLK == 1) ? 32'h0 : 32'h02);

        // Mid-scan reset; a strobe during reset must be ignored.
        rst = 1'b1; sel_in = 3'd6; sel_vld = 1'b1;
        tick();
        check("mrst_out", 32'(out), 32'h0);
        check("mrst_pos", 32'(pos), 32'd0);
        check("mrst_wrap", 32'(wrap), 32'h0);
        rst = 1'b0; sel_vld = 1'b0; mode = 1'b0;
        tick();
        check("post_rst_out", 32'(out), 32'h01);
        check("post_rst_pos", 32'(pos), 32'd0);

        // 16-output instance, dwell=0.
        en = 1'b0;
        en4 = 1'b1; mode4 = 1'b1; dwell4 = 8'd0;
        for (int k = 0; k < 40 * (1 + BLK); k++) begin
            tick();
            check("s4_out", 32'(out4), scan_out(k, 0, 4));
            check("s4_pos", 32'(pos4), 32'(scan_pos(k, 0, 4)));
            check("s4_wrap", 32'(wrap4), scan_wrap(k, 0, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_decoder_scan
`default_nettype wire

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered binary-to-one-hot decoder with latched input and an autonomous scan mode. In DIRECT mode it decodes a strobed select code and holds the result until the next strobe; in SCAN mode it walks the one-hot output through all positions with a programmable dwell. It drives digit/segment enables and other one-hot select lines in the display and I/O paths, replacing fixed-width combinational 3-to-8 decoders.

## Interface
- SEL_W, default 3: select code width; output width is 2**SEL_W.
- DWELL_W, default 16: width of the dwell count.
- sys_clk  in  1  single clock; all logic is rising-edge.
- sys_rst  in  1  synchronous, active-high reset.
- en  in  1  block enable; 0 forces all outputs off.
- mode  in  1  0 = DIRECT, 1 = SCAN.
- sel_in  in  SEL_W  select code, sampled when sel_vld=1.
- sel_vld  in  1  single-cycle strobe that latches sel_in.
- dwell  in  DWELL_W  cycles per scan position minus one.
- out  out  2**SEL_W  registered one-hot (or all-zero) output.
- pos  out  SEL_W  registered binary index of the currently driven position.
- wrap  out  1  one-cycle pulse when the scan returns to position 0.

## Operation
- Reset: out=0, pos=0, wrap=0, latched code=0, dwell counter=0, state OFF.
- States: OFF, DIRECT, SCAN, plus BLANK when DECODER_SCAN_BLANK_EN is defined.
- OFF: out=0, pos holds. When en=1, move to DIRECT if mode=0, else SCAN.
- DIRECT:
  - sel_vld=1 latches sel_in; out becomes 1<<code and pos becomes code.
  - Without a strobe, out and pos hold their value (latch behaviour).
  - out is never all-zero while in DIRECT.
- sel_vld in any state other than DIRECT updates the latched code only; out is unaffected.
- SCAN:
  - Entry sets pos=0, out=1, counter=0.
  - The counter increments every cycle. When counter>=dwell, the counter clears and pos advances to pos+1, wrapping from 2**SEL_W-1 to 0.
  - Each position is held for dwell+1 cycles. dwell=0 advances every cycle.
  - The >= comparison means a live dwell decrease below the current count advances on the next cycle. No stall.
- Mode change while en=1 takes effect on the next edge:
  - DIRECT->SCAN restarts at position 0.
  - SCAN->DIRECT drives the latched code.
- en=0 from any state: OFF on the next edge, out=0, wrap=0. The latched code is retained.
- sys_rst mid-scan: all state returns to reset values on that edge. Reset overrides en and sel_vld.
- wrap=1 for exactly the first cycle that out==1 after leaving position 2**SEL_W-1. wrap is never asserted in DIRECT or OFF.

## Timing
- DIRECT latency: sel_vld sampled at edge N; out and pos are valid after edge N. Back-to-back strobes each take effect.
- en 0->1: out is valid after the following edge, one cycle latency.
- Scan period is 2**SEL_W*(dwell+1) cycles, or 2**SEL_W*(dwell+2) with blanking.
- out and pos always change on the same edge. Both are registered, with no combinational path from any input.

## Configuration
- DECODER_SCAN_BLANK_EN
  - Defined: on dwell expiry, enter BLANK for exactly one cycle with out=0 and pos already at the next index, then return to SCAN driving that position. This provides anti-ghosting for multiplexed displays. en=0 or a mode change during BLANK follows the normal rules.
  - Undefined: the BLANK state does not exist and positions change edge-to-edge.

## Structure
- decoder_scan_pkg holds:
  - the state enum (OFF, DIRECT, SCAN, BLANK);
  - MODE_DIRECT=1'b0 and MODE_SCAN=1'b1;
  - a function computing 2**SEL_W.
- Sub-module onehot_dec is a combinational SEL_W-to-2**SEL_W decoder. It is instantiated once and feeds the out register. Its enable input forces zero.

## Test plan
- Reset, then en=1, mode=0, strobe sel_in=5 -> out=8'b0010_0000, pos=5 one edge later; hold 20 cycles unchanged.
- mode=1, dwell=2 -> out steps 0x01,0x02,...,0x80,0x01, 3 cycles each; wrap pulses once per 24 cycles, coincident with out=0x01.
- dwell=0 with SEL_W=4 -> 16-bit out advances every cycle; wrap every 16 cycles.
- Mid-scan at pos=6: deassert en -> out=0 next edge; reassert -> restart at pos 0. Mid-scan sys_rst -> all outputs 0.
- In SCAN, strobe sel_in=3, then switch to DIRECT -> out=0x08 on the next edge with no further strobe.
- With DECODER_SCAN_BLANK_EN defined, dwell=1 -> out pattern 0x01,0x01,0x00,0x02,0x02,0x00,...; period 24 cycles.
